// File: rtl/alu_issue_seq_pkg.sv
// Shared types for the ALU issue sequencer: ALU op codes, decode fields, FSM states.
package alu_issue_seq_pkg;

    typedef enum logic [3:0] {
        ALU_ADD = 4'b0000,
        ALU_SUB = 4'b0001,
        ALU_AND = 4'b0010,
        ALU_OR  = 4'b0011,
        ALU_XOR = 4'b0100
    } alu_op_t;

    typedef enum logic [1:0] {SRC2_RT, SRC2_IMM, SRC2_ZERO} src2_t;
    typedef enum logic       {EXT_SIGN, EXT_ZERO} ext_t;
    typedef enum logic [1:0] {KIND_ARITH, KIND_SLT, KIND_BRANCH} kind_t;
    typedef enum logic [1:0] {BR_EQ, BR_NE, BR_LEZ, BR_GTZ} br_cond_t;
    typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_RESP} state_t;

    typedef struct packed {
        alu_op_t  alu_op;
        src2_t    src2;
        ext_t     ext;
        kind_t    kind;
        br_cond_t br;
        logic     illegal;
    } dec_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_BLEZ  = 6'b000110;
    localparam logic [5:0] OP_BGTZ  = 6'b000111;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_XOR = 6'b100110;
    localparam logic [5:0] FN_SLT = 6'b101010;

    function automatic logic [31:0] ext_imm(input logic [15:0] imm, input ext_t ext);
        return (ext == EXT_SIGN) ? {{16{imm[15]}}, imm} : {16'h0000, imm};
    endfunction

endpackage

// File: rtl/alu_issue_seq_decode.sv
// Combinational opcode/funct decode into ALU op, operand-2 source, extension, kind, branch cond.
// Zero latency; no flow control of its own.
module alu_issue_seq_decode
    import alu_issue_seq_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output dec_t       dec
);

    always_comb begin
        dec.alu_op  = ALU_ADD;
        dec.src2    = SRC2_RT;
        dec.ext     = EXT_SIGN;
        dec.kind    = KIND_ARITH;
        dec.br      = BR_EQ;
        dec.illegal = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_ADD:  dec.alu_op = ALU_ADD;
                    FN_SUB:  dec.alu_op = ALU_SUB;
                    FN_AND:  dec.alu_op = ALU_AND;
                    FN_OR:   dec.alu_op = ALU_OR;
                    FN_XOR:  dec.alu_op = ALU_XOR;
                    FN_SLT: begin
                        dec.alu_op = ALU_SUB;
                        dec.kind   = KIND_SLT;
                    end
                    default: dec.illegal = 1'b1;
                endcase
            end
            OP_ADDI, OP_LW, OP_SW: begin
                dec.alu_op = ALU_ADD;
                dec.src2   = SRC2_IMM;
            end
            OP_SLTI: begin
                dec.alu_op = ALU_SUB;
                dec.src2   = SRC2_IMM;
                dec.kind   = KIND_SLT;
            end
            OP_ANDI, OP_ORI, OP_XORI: begin
                dec.src2 = SRC2_IMM;
                dec.ext  = EXT_ZERO;
                dec.alu_op = (opcode == OP_ANDI) ? ALU_AND :
                             (opcode == OP_ORI)  ? ALU_OR  : ALU_XOR;
            end
            OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: begin
                dec.alu_op = ALU_SUB;
                dec.kind   = KIND_BRANCH;
                dec.src2   = (opcode == OP_BEQ || opcode == OP_BNE) ? SRC2_RT : SRC2_ZERO;
                dec.br     = (opcode == OP_BEQ) ? BR_EQ :
                             (opcode == OP_BNE) ? BR_NE :
                             (opcode == OP_BLEZ) ? BR_LEZ : BR_GTZ;
            end
            default: dec.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_issue_seq.sv
// Issue/retire sequencer in front of a 32-bit ALU: one instruction in, one response out.
// Response 2 cycles after accept (illegal: 1); req_ready low in EXEC/RESP, RESP held until rsp_ready.
module alu_issue_seq
    import alu_issue_seq_pkg::*;
#(
    parameter logic [31:0] ILLEGAL_RESULT = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [5:0]  req_opcode,
    input  logic [5:0]  req_funct,
    input  logic [31:0] req_rs_val,
    input  logic [31:0] req_rt_val,
    input  logic [15:0] req_imm,
    output logic [31:0] alu_data1,
    output logic [31:0] alu_data2,
    output logic [3:0]  alu_op,
    input  logic [31:0] alu_result,
    input  logic        alu_zero,
    input  logic        alu_lt,
    input  logic        alu_gt,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_result,
    output logic        rsp_taken,
    output logic        rsp_illegal
);

    state_t   state, state_nxt;
    logic     started;
    dec_t     dec;
    kind_t    kind_q;
    br_cond_t br_q;
    logic     accept;
    logic     br_hit;
    logic [31:0] src2_val;

    alu_issue_seq_decode u_decode (
        .opcode (req_opcode),
        .funct  (req_funct),
        .dec    (dec)
    );

    // started holds req_ready low until the first edge after reset release
    assign req_ready = started && (state == ST_IDLE);
    assign accept    = req_valid && req_ready;
    assign rsp_valid = (state == ST_RESP);

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (accept) state_nxt = dec.illegal ? ST_RESP : ST_EXEC;
            ST_EXEC: state_nxt = ST_RESP;
            ST_RESP: if (rsp_ready) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            started <= 1'b0;
        end else begin
            state   <= state_nxt;
            started <= 1'b1;
        end
    end

    always_comb begin
        case (dec.src2)
            SRC2_IMM:  src2_val = ext_imm(req_imm, dec.ext);
            SRC2_ZERO: src2_val = 32'h0000_0000;
            default:   src2_val = req_rt_val;
        endcase
    end

    // lt/gt are stale on equal operands, so every condition gates them with !zero
    always_comb begin
        case (br_q)
            BR_EQ:   br_hit = alu_zero;
            BR_NE:   br_hit = !alu_zero;
            BR_LEZ:  br_hit = alu_zero || alu_lt;
            default: br_hit = !alu_zero && alu_gt;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_data1   <= '0;
            alu_data2   <= '0;
            alu_op      <= ALU_ADD;
            kind_q      <= KIND_ARITH;
            br_q        <= BR_EQ;
            rsp_result  <= '0;
            rsp_taken   <= 1'b0;
            rsp_illegal <= 1'b0;
        end else if (accept) begin
            rsp_taken   <= 1'b0;
            rsp_illegal <= dec.illegal;
            if (dec.illegal) begin
                rsp_result <= ILLEGAL_RESULT;
            end else begin
                alu_data1 <= req_rs_val;
                alu_data2 <= src2_val;
                alu_op    <= dec.alu_op;
                kind_q    <= dec.kind;
                br_q      <= dec.br;
            end
        end else if (state == ST_EXEC) begin
            rsp_result <= (kind_q == KIND_SLT) ? {31'b0, !alu_zero && alu_lt} : alu_result;
            rsp_taken  <= (kind_q == KIND_BRANCH) && br_hit;
        end
    end

endmodule

// File: tb/tb_alu_issue_seq.sv
// Randomized bench for alu_issue_seq with a behavioural ALU and MIPS-level reference model.
module tb_alu_issue_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [5:0]  req_opcode = '0;
    logic [5:0]  req_funct = '0;
    logic [31:0] req_rs_val = '0;
    logic [31:0] req_rt_val = '0;
    logic [15:0] req_imm = '0;
    logic [31:0] alu_data1, alu_data2;
    logic [3:0]  alu_op;
    logic [31:0] alu_result;
    logic        alu_zero, alu_lt, alu_gt;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_result;
    logic        rsp_taken, rsp_illegal;

    logic stale_lt = 1'b0;
    logic stale_gt = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    localparam logic [31:0] ILLEGAL_RESULT = 32'h0000_0000;

    alu_issue_seq #(.ILLEGAL_RESULT(ILLEGAL_RESULT)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_opcode(req_opcode), .req_funct(req_funct),
        .req_rs_val(req_rs_val), .req_rt_val(req_rt_val), .req_imm(req_imm),
        .alu_data1(alu_data1), .alu_data2(alu_data2), .alu_op(alu_op),
        .alu_result(alu_result), .alu_zero(alu_zero), .alu_lt(alu_lt), .alu_gt(alu_gt),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_taken(rsp_taken), .rsp_illegal(rsp_illegal)
    );

    always #5 clk = ~clk;

    // ALU stand-in; lt/gt deliberately carry junk when the operands are equal
    always_comb begin
        case (alu_op)
            4'b0000: alu_result = alu_data1 + alu_data2;
            4'b0001: alu_result = alu_data1 - alu_data2;
            4'b0010: alu_result = alu_data1 & alu_data2;
            4'b0011: alu_result = alu_data1 | alu_data2;
            4'b0100: alu_result = alu_data1 ^ alu_data2;
            default: alu_result = 32'h0;
        endcase
        alu_zero = (alu_data1 == alu_data2);
        alu_lt   = alu_zero ? stale_lt : ($signed(alu_data1) < $signed(alu_data2));
        alu_gt   = alu_zero ? stale_gt : ($signed(alu_data1) > $signed(alu_data2));
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic        ok;
        logic [3:0]  op;
        logic [31:0] d1, d2, res;
        logic        taken;
    } exp_t;

    function automatic exp_t model(input logic [5:0] opc, input logic [5:0] fn,
                                   input logic [31:0] rs, input logic [31:0] rt,
                                   input logic [15:0] imm);
        exp_t e;
        logic [31:0] sx, zx;
        sx = {{16{imm[15]}}, imm};
        zx = {16'h0, imm};
        e.ok = 1'b1; e.taken = 1'b0; e.d1 = rs; e.d2 = rt; e.op = 4'b0000; e.res = 32'h0;
        case (opc)
            6'd0: case (fn)
                6'h20: begin e.op = 4'd0; e.res = rs + rt; end
                6'h22: begin e.op = 4'd1; e.res = rs - rt; end
                6'h24: begin e.op = 4'd2; e.res = rs & rt; end
                6'h25: begin e.op = 4'd3; e.res = rs | rt; end
                6'h26: begin e.op = 4'd4; e.res = rs ^ rt; end
                6'h2a: begin e.op = 4'd1; e.res = ($signed(rs) < $signed(rt)) ? 32'd1 : 32'd0; end
                default: e.ok = 1'b0;
            endcase
            6'h08, 6'h23, 6'h2b: begin e.op = 4'd0; e.d2 = sx; e.res = rs + sx; end
            6'h0a: begin e.op = 4'd1; e.d2 = sx; e.res = ($signed(rs) < $signed(sx)) ? 32'd1 : 32'd0; end
            6'h0c: begin e.op = 4'd2; e.d2 = zx; e.res = rs & zx; end
            6'h0d: begin e.op = 4'd3; e.d2 = zx; e.res = rs | zx; end
            6'h0e: begin e.op = 4'd4; e.d2 = zx; e.res = rs ^ zx; end
            6'h04: begin e.op = 4'd1; e.res = rs - rt; e.taken = (rs == rt); end
            6'h05: begin e.op = 4'd1; e.res = rs - rt; e.taken = (rs != rt); end
            6'h06: begin e.op = 4'd1; e.d2 = 0; e.res = rs; e.taken = ($signed(rs) <= 0); end
            6'h07: begin e.op = 4'd1; e.d2 = 0; e.res = rs; e.taken = ($signed(rs) > 0); end
            default: e.ok = 1'b0;
        endcase
        if (!e.ok) begin
            e.res = ILLEGAL_RESULT;
            e.taken = 1'b0;
        end
        return e;
    endfunction

    task automatic wait_ready();
        for (int i = 0; i < 20 && !req_ready; i++) @(negedge clk);
        check("req_ready_idle", {31'b0, req_ready}, 32'd1);
    endtask

    task automatic run_instr(input logic [5:0] opc, input logic [5:0] fn,
                             input logic [31:0] rs, input logic [31:0] rt,
                             input logic [15:0] imm, input int hold);
        exp_t e;
        logic [3:0]  prev_op;
        logic [31:0] prev_d1, prev_d2;
        e = model(opc, fn, rs, rt, imm);
        stale_lt = 1'($urandom);
        stale_gt = 1'($urandom);
        wait_ready();
        prev_op = alu_op; prev_d1 = alu_data1; prev_d2 = alu_data2;
        req_opcode = opc; req_funct = fn; req_rs_val = rs; req_rt_val = rt; req_imm = imm;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        check("req_ready_busy", {31'b0, req_ready}, 32'd0);
        if (e.ok) begin
            check("alu_op", {28'b0, alu_op}, {28'b0, e.op});
            check("alu_data1", alu_data1, e.d1);
            check("alu_data2", alu_data2, e.d2);
            check("rsp_valid_exec", {31'b0, rsp_valid}, 32'd0);
            check("taken_cleared", {31'b0, rsp_taken}, 32'd0);
            @(negedge clk);
        end else begin
            check("illegal_alu_op_kept", {28'b0, alu_op}, {28'b0, prev_op});
            check("illegal_d1_kept", alu_data1, prev_d1);
            check("illegal_d2_kept", alu_data2, prev_d2);
        end
        check("rsp_valid", {31'b0, rsp_valid}, 32'd1);
        check("rsp_result", rsp_result, e.res);
        check("rsp_taken", {31'b0, rsp_taken}, {31'b0, e.taken});
        check("rsp_illegal", {31'b0, rsp_illegal}, {31'b0, !e.ok});
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_valid", {31'b0, rsp_valid}, 32'd1);
            check("hold_result", rsp_result, e.res);
            check("hold_taken", {31'b0, rsp_taken}, {31'b0, e.taken});
            check("hold_req_ready", {31'b0, req_ready}, 32'd0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("rsp_valid_done", {31'b0, rsp_valid}, 32'd0);
        check("req_ready_back", {31'b0, req_ready}, 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"}, {31'b0, req_ready}, 32'd0);
        check({tag, "_rsp_valid"}, {31'b0, rsp_valid}, 32'd0);
        check({tag, "_d1"}, alu_data1, 32'd0);
        check({tag, "_d2"}, alu_data2, 32'd0);
        check({tag, "_op"}, {28'b0, alu_op}, 32'd0);
        check({tag, "_result"}, rsp_result, 32'd0);
        check({tag, "_taken"}, {31'b0, rsp_taken}, 32'd0);
        check({tag, "_illegal"}, {31'b0, rsp_illegal}, 32'd0);
    endtask

    logic [5:0] legal_ops [15] = '{6'h00, 6'h00, 6'h00, 6'h08, 6'h0a, 6'h0c, 6'h0d,
                                   6'h0e, 6'h23, 6'h2b, 6'h04, 6'h05, 6'h06, 6'h07, 6'h00};
    logic [5:0] legal_fns [6] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h2a};

    initial begin
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        #1 check("ready_before_edge", {31'b0, req_ready}, 32'd0);
        @(negedge clk);

        run_instr(6'h00, 6'h20, 32'd5, 32'd7, 16'h0, 0);
        run_instr(6'h0a, 6'h00, 32'hFFFF_FFFD, 32'h0, 16'hFFFE, 0);
        run_instr(6'h0a, 6'h00, 32'hFFFF_FFFE, 32'h0, 16'hFFFE, 0);
        run_instr(6'h04, 6'h00, 32'h1234, 32'h1234, 16'h0, 0);
        run_instr(6'h07, 6'h00, 32'h0, 32'h55, 16'h0, 0);
        run_instr(6'h06, 6'h00, 32'h8000_0000, 32'h0, 16'h0, 0);
        run_instr(6'h3f, 6'h00, 32'h1, 32'h2, 16'h3, 0);
        run_instr(6'h05, 6'h00, 32'h9, 32'h8, 16'h0, 0);
        run_instr(6'h00, 6'h3f, 32'h1, 32'h2, 16'h0, 0);
        run_instr(6'h00, 6'h22, 32'h0, 32'h1, 16'h0, 5);
        run_instr(6'h0d, 6'h00, 32'hF000_0000, 32'h0, 16'h8001, 0);

        for (int n = 0; n < 150; n++) begin
            logic [5:0]  opc, fn;
            logic [31:0] rs, rt;
            logic [15:0] imm;
            opc = ($urandom_range(0, 9) == 0) ? 6'($urandom) : legal_ops[$urandom_range(0, 14)];
            fn  = ($urandom_range(0, 9) == 0) ? 6'($urandom) : legal_fns[$urandom_range(0, 5)];
            rs  = $urandom;
            rt  = ($urandom_range(0, 3) == 0) ? rs : $urandom;
            imm = 16'($urandom);
            if ($urandom_range(0, 7) == 0) rs = 0;
            if ($urandom_range(0, 7) == 0) rs = {{16{imm[15]}}, imm};
            run_instr(opc, fn, rs, rt, imm, $urandom_range(0, 3));
        end

        wait_ready();
        req_opcode = 6'h00; req_funct = 6'h20; req_rs_val = 32'h11; req_rt_val = 32'h22;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        check("exec_before_reset", {31'b0, rsp_valid}, 32'd0);
        rst_n = 1'b0;
        #1 check_reset_outputs("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("post_reset_no_rsp", {31'b0, rsp_valid}, 32'd0);
            check("post_reset_ready", {31'b0, req_ready}, 32'd1);
        end
        run_instr(6'h00, 6'h26, 32'hA5A5_A5A5, 32'hFFFF_0000, 16'h0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
